led_mode_ctrl: RTL and testbench



---
 rtl/misc.sv | 48 ++++
 rtl/tick_prescaler.sv | 36 +++
 rtl/led_mode_ctrl.sv | 73 +++++++
 tb/tb_led_mode_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/misc.sv
// Shared board-level constants and types.
//   FREQUENCY_*             common system clock rates in Hz
//   BASE_FREQUENCY_DEFAULT  default shared blink tick rate in Hz
//   led_mode_t              per-channel blink mode (OFF, SLOW, MEDIUM, FAST)
//   DIV_*                   base ticks per LED toggle for each blinking mode
package misc;

  localparam int unsigned FREQUENCY_25MHZ        = 25_000_000;
  localparam int unsigned FREQUENCY_50MHZ        = 50_000_000;
  localparam int unsigned FREQUENCY_100MHZ       = 100_000_000;
  localparam int unsigned BASE_FREQUENCY_DEFAULT = 10;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    SLOW   = 2'd1,
    MEDIUM = 2'd2,
    FAST   = 2'd3
  } led_mode_t;

  localparam logic [3:0] DIV_SLOW   = 4'd10;
  localparam logic [3:0] DIV_MEDIUM = 4'd2;
  localparam logic [3:0] DIV_FAST   = 4'd1;

  // Press sequence: OFF -> SLOW -> MEDIUM -> FAST -> OFF.
  function automatic led_mode_t next_mode(input led_mode_t m);
    led_mode_t n;
    unique case (m)
      OFF:     n = SLOW;
      SLOW:    n = MEDIUM;
      MEDIUM:  n = FAST;
      default: n = OFF;
    endcase
    return n;
  endfunction

  // OFF never consults its divisor; any nonzero value is harmless there.
  function automatic logic [3:0] mode_divisor(input led_mode_t m);
    logic [3:0] d;
    unique case (m)
      SLOW:    d = DIV_SLOW;
      MEDIUM:  d = DIV_MEDIUM;
      FAST:    d = DIV_FAST;
      default: d = 4'd1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler producing one single-cycle tick every
// CLOCK_FREQUENCY/BASE_FREQUENCY clocks (PRESCALE, must be >= 2).
//   clock    system clock
//   reset_n  asynchronous active-low reset
//   tick     high for the one cycle in which the count equals PRESCALE-1
module tick_prescaler
  import misc::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = FREQUENCY_50MHZ,
  parameter int unsigned BASE_FREQUENCY  = BASE_FREQUENCY_DEFAULT
) (
  input  logic clock,
  input  logic reset_n,
  output logic tick
);

  localparam int unsigned PRESCALE   = CLOCK_FREQUENCY / BASE_FREQUENCY;
  localparam int unsigned CountWidth = $clog2(PRESCALE);
  localparam logic [CountWidth-1:0] LastCount = CountWidth'(PRESCALE - 1);

  logic [CountWidth-1:0] count_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (count_q == LastCount) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CountWidth'(1);
    end
  end

  // Decoded straight from the count so the tick lines up with count==PRESCALE-1.
  assign tick = (count_q == LastCount);

endmodule

// File: rtl/led_mode_ctrl.sv
// Per-channel blink-mode controller. Each press pulse steps its channel through
// OFF -> SLOW -> MEDIUM -> FAST -> OFF; every channel divides the shared base
// tick by its mode's divisor and toggles its LED on each divided tick.
//   clock           system clock
//   reset_n         asynchronous active-low reset
//   button_pressed  one-cycle synchronized press pulses, one per channel
//   disable_all     synchronous level, forces every channel to OFF
//   led             LED outputs
//   mode            current mode, channel i on bits [2i+1:2i]
//   base_tick       shared prescaler pulse
module led_mode_ctrl
  import misc::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = FREQUENCY_50MHZ,
  parameter int unsigned BASE_FREQUENCY  = BASE_FREQUENCY_DEFAULT,
  parameter int unsigned NUM_CHANNELS    = 3
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_CHANNELS-1:0]   button_pressed,
  input  logic                      disable_all,
  output logic [NUM_CHANNELS-1:0]   led,
  output logic [2*NUM_CHANNELS-1:0] mode,
  output logic                      base_tick
);

  tick_prescaler #(
    .CLOCK_FREQUENCY (CLOCK_FREQUENCY),
    .BASE_FREQUENCY  (BASE_FREQUENCY)
  ) u_prescaler (
    .clock   (clock),
    .reset_n (reset_n),
    .tick    (base_tick)
  );

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_channel
    led_mode_t  mode_q;
    logic [3:0] div_q;
    logic       led_q;

    // Priority: disable_all > press > OFF hold > divided tick. Any mode change
    // restarts the phase, so the first toggle lands a full divisor later.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        mode_q <= OFF;
        div_q  <= 4'd0;
        led_q  <= 1'b0;
      end else if (disable_all) begin
        mode_q <= OFF;
        div_q  <= 4'd0;
        led_q  <= 1'b0;
      end else if (button_pressed[i]) begin
        mode_q <= next_mode(mode_q);
        div_q  <= 4'd0;
        led_q  <= 1'b0;
      end else if (mode_q == OFF) begin
        div_q  <= 4'd0;
        led_q  <= 1'b0;
      end else if (base_tick) begin
        if (div_q == mode_divisor(mode_q) - 4'd1) begin
          div_q <= 4'd0;
          led_q <= ~led_q;
        end else begin
          div_q <= div_q + 4'd1;
        end
      end
    end

    assign led[i]       = led_q;
    assign mode[2*i +: 2] = mode_q;
  end

endmodule

// File: tb/tb_led_mode_ctrl.sv
module tb_led_mode_ctrl;

  logic       clock;
  logic       reset_n;
  logic [2:0] button_pressed;
  logic       disable_all;
  logic [2:0] led;
  logic [5:0] mode;
  logic       base_tick;

  int n_vec;
  int n_err;

  led_mode_ctrl #(
    .CLOCK_FREQUENCY (100),
    .BASE_FREQUENCY  (10),
    .NUM_CHANNELS    (3)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .button_pressed (button_pressed),
    .disable_all    (disable_all),
    .led            (led),
    .mode           (mode),
    .base_tick      (base_tick)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [2:0] press;
    logic       dis;
    logic [5:0] exp_mode;
    logic [2:0] exp_led;
    logic       exp_tick;
  } vec_t;

  vec_t tab[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Inputs change and outputs are sampled at the falling edge.
  task automatic step();
    @(negedge clock);
  endtask

  // Returns when base_tick is visible, i.e. the next rising edge is a tick edge.
  task automatic wait_tick();
    int n = 0;
    while (!base_tick && n < 20) begin
      step();
      n++;
    end
    if (!base_tick) check("tick_timeout", 32'(base_tick), 32'd1);
  endtask

  // LED image k cycles after the frequency setup reference (all on tick phase 0).
  function automatic logic [2:0] freq_led(input int k);
    logic [2:0] r;
    r[0] = ((k / 10) % 2) != 0;
    r[1] = ((k / 20) % 2) != 0;
    r[2] = ((k / 100) % 2) != 0;
    return r;
  endfunction

  initial begin
    int n;
    n_vec          = 0;
    n_err          = 0;
    reset_n        = 1'b0;
    button_pressed = 3'b000;
    disable_all    = 1'b0;

    // Bit order of mode: {ch2, ch1, ch0}, two bits each.
    tab[0] = '{3'b001, 1'b0, 6'b000001, 3'b000, 1'b0};
    tab[1] = '{3'b000, 1'b0, 6'b000001, 3'b000, 1'b0};
    tab[2] = '{3'b001, 1'b0, 6'b000010, 3'b000, 1'b0};
    tab[3] = '{3'b010, 1'b0, 6'b000110, 3'b000, 1'b0};
    tab[4] = '{3'b101, 1'b0, 6'b010111, 3'b000, 1'b0};
    tab[5] = '{3'b010, 1'b1, 6'b000000, 3'b000, 1'b0};
    tab[6] = '{3'b111, 1'b0, 6'b010101, 3'b000, 1'b0};
    tab[7] = '{3'b001, 1'b0, 6'b010110, 3'b000, 1'b0};
    tab[8] = '{3'b000, 1'b0, 6'b010110, 3'b000, 1'b1};
    tab[9] = '{3'b000, 1'b0, 6'b010110, 3'b000, 1'b0};

    #1;
    check("reset_outputs", 32'({led, mode, base_tick}), 32'd0);
    step();
    reset_n = 1'b1;

    // Table: vector i is clocked by rising edge i+1 after reset release.
    for (int i = 0; i < 10; i++) begin
      button_pressed = tab[i].press;
      disable_all    = tab[i].dis;
      step();
      check($sformatf("vec%0d_mode", i), 32'(mode), 32'(tab[i].exp_mode));
      check($sformatf("vec%0d_led", i), 32'(led), 32'(tab[i].exp_led));
      check($sformatf("vec%0d_tick", i), 32'(base_tick), 32'(tab[i].exp_tick));
    end
    button_pressed = 3'b000;
    disable_all    = 1'b0;

    // Asynchronous reset while an LED is lit.
    n = 0;
    while (led == 3'b000 && n < 50) begin
      step();
      n++;
    end
    check("blink_before_reset", 32'(led != 3'b000), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_led", 32'(led), 32'd0);
    check("async_reset_mode", 32'(mode), 32'd0);
    check("async_reset_tick", 32'(base_tick), 32'd0);
    step();
    reset_n = 1'b1;

    // Tick visible after rising edges 9, 19, 29 following release.
    for (int k = 1; k <= 30; k++) begin
      step();
      check($sformatf("tick_edge%0d", k), 32'(base_tick), 32'(k % 10 == 9));
    end

    // Four presses on channel 0, five cycles apart.
    for (int j = 1; j <= 4; j++) begin
      button_pressed = 3'b001;
      for (int c = 0; c < 5; c++) begin
        step();
        button_pressed = 3'b000;
        check($sformatf("cycle_press%0d_c%0d", j, c), 32'(mode), 32'(j % 4));
      end
    end

    // ch2 SLOW, ch1 MEDIUM, ch0 FAST, entered just after a tick edge.
    wait_tick();
    step();
    for (int k = 1; k <= 200; k++) begin
      button_pressed = (k == 1) ? 3'b111 : (k == 2) ? 3'b011 : (k == 3) ? 3'b001 : 3'b000;
      step();
      check($sformatf("freq_k%0d", k), 32'(led), 32'(freq_led(k)));
    end
    button_pressed = 3'b000;
    check("freq_modes", 32'(mode), 32'(6'b011011));

    // Press on FAST exactly on the tick edge: mode OFF, no toggle.
    wait_tick();
    button_pressed = 3'b001;
    step();
    button_pressed = 3'b000;
    check("collide_mode", 32'(mode), 32'(6'b011000));
    check("collide_led", 32'(led), 32'd0);

    // Second tick-aligned press: SLOW from a cleared divider.
    wait_tick();
    button_pressed = 3'b001;
    step();
    button_pressed = 3'b000;
    check("collide2_mode", 32'(mode[1:0]), 32'd1);
    check("collide2_led", 32'(led[0]), 32'd0);
    for (int t = 1; t <= 10; t++) begin
      wait_tick();
      step();
      check($sformatf("slow_tick%0d", t), 32'(led[0]), 32'(t == 10));
    end

    // disable_all beats a simultaneous press.
    disable_all    = 1'b1;
    button_pressed = 3'b010;
    step();
    disable_all    = 1'b0;
    button_pressed = 3'b000;
    check("disable_mode", 32'(mode), 32'd0);
    check("disable_led", 32'(led), 32'd0);
    step();
    check("disable_hold_mode", 32'(mode), 32'd0);
    check("disable_hold_led", 32'(led), 32'd0);

    // Channel 1 MEDIUM keeps its phase while channel 0 is pressed repeatedly.
    button_pressed = 3'b010;
    step();
    step();
    button_pressed = 3'b000;
    check("indep_mode", 32'(mode[3:2]), 32'd2);
    n = 0;
    while (!led[1] && n < 100) begin
      step();
      n++;
    end
    check("indep_first_rise", 32'(led[1]), 32'd1);
    for (int k = 1; k <= 100; k++) begin
      button_pressed = (k % 7 == 3) ? 3'b001 : 3'b000;
      step();
      check($sformatf("indep_k%0d", k), 32'(led[1]), 32'(((k / 20) + 1) % 2));
    end
    button_pressed = 3'b000;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
